// File: rtl/counter_pkg.sv
// Shared constants and helpers for the free-running counter family.
// The default build is a 4-bit modulo-16 timebase.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_MAX   = (1 << DEFAULT_WIDTH) - 1;

    function automatic logic [DEFAULT_WIDTH-1:0] bin2gray(input logic [DEFAULT_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/counter_core.sv
// Binary count register with compare-based wrap at MAX.
// Exposes the next value so sibling flops can stay aligned with the count.
module counter_core
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int MAX   = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] next_count,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    // Compare rather than rely on overflow so non-power-of-two MAX works.
    always_comb begin
        at_max     = (count == MAX_VAL);
        next_count = at_max ? '0 : count + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/four_bit_counter.sv
// Free-running modulo-(MAX+1) counter with terminal-count, wrap-pulse
// and registered Gray-coded views of the count.
module four_bit_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int MAX   = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic [WIDTH-1:0] count_gray
);

    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] next_gray;
    logic             at_max;

    counter_core #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .next_count (next_count),
        .at_max     (at_max)
    );

    generate
        if (WIDTH == DEFAULT_WIDTH) begin : g_gray_pkg
            assign next_gray = bin2gray(next_count);
        end else begin : g_gray_generic
            assign next_gray = next_count ^ (next_count >> 1);
        end
    endgenerate

    assign tc = at_max;

    // Gray is encoded from the next count so it lands in the same cycle as count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap       <= 1'b0;
            count_gray <= '0;
        end else begin
            wrap       <= at_max;
            count_gray <= next_gray;
        end
    end

`ifdef COUNTER_SIM_ASSERTIONS
    always @(posedge clk) begin
        if (reset) begin
            assert (count <= WIDTH'(MAX));
            assert (count_gray == (count ^ (count >> 1)));
            assert (!(tc && wrap));
        end
    end
`endif

endmodule

// File: tb/tb_four_bit_counter.sv
// Randomised directed bench for four_bit_counter: a default modulo-16 build
// and a modulo-10 build share clock and reset, checked against a period model.
module tb_four_bit_counter;

    logic       clk;
    logic       reset;
    logic [3:0] count16, gray16, count10, gray10;
    logic       tc16, wrap16, tc10, wrap10;

    int  passes;
    int  total;
    int  edges;
    bit  running;

    four_bit_counter dut16 (
        .clk        (clk),
        .reset      (reset),
        .count      (count16),
        .tc         (tc16),
        .wrap       (wrap16),
        .count_gray (gray16)
    );

    four_bit_counter #(.WIDTH(4), .MAX(9)) dut10 (
        .clk        (clk),
        .reset      (reset),
        .count      (count10),
        .tc         (tc10),
        .wrap       (wrap10),
        .count_gray (gray10)
    );

    always #5 clk = ~clk;

    // Model: the count is the number of live edges since release, modulo the period.
    function automatic int expCount(input int maxVal);
        return running ? (edges % (maxVal + 1)) : 0;
    endfunction

    function automatic int expWrap(input int maxVal);
        return (running && edges >= maxVal + 1 && expCount(maxVal) == 0) ? 1 : 0;
    endfunction

    task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d (edges=%0d)", tag, observed, expected, edges);
    endtask

    task automatic checkOutput();
        int c16, c10;
        c16 = expCount(15);
        c10 = expCount(9);
        checkOne("count16", 32'(count16), 32'(c16));
        checkOne("tc16",    32'(tc16),    32'(c16 == 15));
        checkOne("wrap16",  32'(wrap16),  32'(expWrap(15)));
        checkOne("gray16",  32'(gray16),  32'(c16 ^ (c16 >> 1)));
        checkOne("count10", 32'(count10), 32'(c10));
        checkOne("tc10",    32'(tc10),    32'(c10 == 9));
        checkOne("wrap10",  32'(wrap10),  32'(expWrap(9)));
        checkOne("gray10",  32'(gray10),  32'(c10 ^ (c10 >> 1)));
    endtask

    task automatic applyStimulus(input int n);
        logic [3:0] prevGray;
        for (int i = 0; i < n; i++) begin
            prevGray = gray16;
            @(posedge clk);
            if (running) edges++;
            @(negedge clk);
            checkOutput();
            if (running) checkOne("gray16_step", 32'($countones(prevGray ^ gray16)), 32'd1);
        end
    endtask

    task automatic dropResetMidCycle(input int offset);
        #(offset);
        reset   = 1'b0;
        running = 1'b0;
        edges   = 0;
        #1;
        checkOutput();
    endtask

    initial begin
        int guard;
        clk     = 1'b0;
        reset   = 1'b0;
        running = 1'b0;
        edges   = 0;
        passes  = 0;
        total   = 0;

        // Held in reset: clock edges must not move anything.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput();
        end

        // Release between edges, then two full periods of the default build.
        reset   = 1'b1;
        running = 1'b1;
        applyStimulus(32);
        applyStimulus(int'($urandom_range(3, 20)));

        // Advance to count 9 and drop reset between edges.
        guard = 0;
        while (expCount(15) != 9 && guard < 20) begin
            applyStimulus(1);
            guard++;
        end
        checkOne("reach9", 32'(count16), 32'd9);
        dropResetMidCycle(2);
        @(negedge clk);
        reset   = 1'b1;
        running = 1'b1;
        applyStimulus(1);
        checkOne("first_after_release", 32'(count16), 32'd1);

        // Release coincident with a rising edge: that edge must not count.
        dropResetMidCycle(1);
        @(negedge clk);
        @(posedge clk);
        #0 reset = 1'b1;
        running = 1'b1;
        @(negedge clk);
        checkOutput();
        applyStimulus(1);
        checkOne("coincident_release", 32'(count16), 32'd1);

        // Random run lengths interrupted by asynchronous resets.
        for (int r = 0; r < 6; r++) begin
            applyStimulus(int'($urandom_range(5, 40)));
            dropResetMidCycle(int'($urandom_range(1, 3)));
            applyStimulus(int'($urandom_range(1, 3)));
            @(negedge clk);
            reset   = 1'b1;
            running = 1'b1;
        end
        applyStimulus(25);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
